// File: rtl/z_hilo_writeback.sv
// Z-pair capture and HI/LO writeback stage behind the multiplier/divider.
// A self-timed start/busy/done sequence copies Z low then Z high into LO/HI.
module z_hilo_writeback #(
  parameter int W = 32
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic           start,
  input  logic [2*W-1:0] result,
  input  logic           HIin,
  input  logic           LOin,
  input  logic [W-1:0]   bus_in,
  input  logic           HIout,
  input  logic           LOout,
  output logic [W-1:0]   bus_out,
  output logic [W-1:0]   HI,
  output logic [W-1:0]   LO,
  output logic [2*W-1:0] Z,
  output logic           busy,
  output logic           done,
  output logic           z_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic capture;
  logic write_lo;
  logic write_hi;
  logic load_hi;
  logic load_lo;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start in IDLE always beats the mthi/mtlo bus loads in the same cycle.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    write_lo   = 1'b0;
    write_hi   = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          capture    = 1'b1;
          state_next = WR_LO;
        end else begin
          load_hi = HIin;
          load_lo = LOin;
        end
      end
      WR_LO: begin
        write_lo   = 1'b1;
        state_next = WR_HI;
      end
      WR_HI: begin
        write_hi   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      Z      <= '0;
      z_zero <= 1'b0;
    end else if (capture) begin
      Z      <= result;
      z_zero <= (result == '0);
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      LO <= '0;
    end else if (write_lo) begin
      LO <= Z[W-1:0];
    end else if (load_lo) begin
      LO <= bus_in;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      HI <= '0;
    end else if (write_hi) begin
      HI <= Z[2*W-1:W];
    end else if (load_hi) begin
      HI <= bus_in;
    end
  end

  always_comb begin
    bus_out = '0;
    if (HIout) begin
      bus_out = HI;
    end else if (LOout) begin
      bus_out = LO;
    end
  end

endmodule

// File: tb/tb_z_hilo_writeback.sv
// Randomized scoreboard bench for z_hilo_writeback: a per-edge behavioural
// model predicts HI/LO/Z/busy, and a monitor pops expected writebacks on done.
module tb_z_hilo_writeback;
  localparam int W = 32;

  logic           Clock = 1'b0;
  logic           Clear;
  logic           start;
  logic [2*W-1:0] result;
  logic           HIin;
  logic           LOin;
  logic [W-1:0]   bus_in;
  logic           HIout;
  logic           LOout;
  logic [W-1:0]   bus_out;
  logic [W-1:0]   HI;
  logic [W-1:0]   LO;
  logic [2*W-1:0] Z;
  logic           busy;
  logic           done;
  logic           z_zero;

  z_hilo_writeback #(.W(W)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .result(result),
    .HIin(HIin), .LOin(LOin), .bus_in(bus_in), .HIout(HIout), .LOout(LOout),
    .bus_out(bus_out), .HI(HI), .LO(LO), .Z(Z), .busy(busy), .done(done),
    .z_zero(z_zero)
  );

  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;
  int edge_cnt   = 0;

  always @(posedge Clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int             done_edge;
    logic [2*W-1:0] z;
  } exp_t;
  exp_t sb[$];

  // Model: architectural state after the most recent edge, plus the edge of
  // the last accepted start and the first edge a new start may be accepted.
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;
  logic [2*W-1:0] m_z;
  logic           m_zz;
  int             acc_edge;
  int             next_ok;

  task automatic checkOutput(input string name, input logic [2*W-1:0] act,
                             input logic [2*W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h expected 0x%0h",
               name, edge_cnt, act, exp);
    end
  endtask

  task automatic resetModel();
    m_hi     = '0;
    m_lo     = '0;
    m_z      = '0;
    m_zz     = 1'b0;
    acc_edge = -100;
    next_ok  = 0;
    sb.delete();
  endtask

  task automatic applyStimulus(input logic s, input logic [2*W-1:0] r,
                               input logic hin, input logic lin,
                               input logic [W-1:0] b, input logic hout,
                               input logic lout);
    int e;
    @(negedge Clock);
    #1;
    checkOutput("HI", HI, m_hi);
    checkOutput("LO", LO, m_lo);
    checkOutput("Z", Z, m_z);
    checkOutput("z_zero", z_zero, m_zz);
    checkOutput("busy", busy, (edge_cnt >= acc_edge && edge_cnt <= acc_edge + 2));
    start  = s;
    result = r;
    HIin   = hin;
    LOin   = lin;
    bus_in = b;
    HIout  = hout;
    LOout  = lout;
    #1;
    checkOutput("bus_out", bus_out, hout ? m_hi : (lout ? m_lo : '0));
    // Predict the state after the coming edge.
    e = edge_cnt + 1;
    if (e == acc_edge + 1) m_lo = m_z[W-1:0];
    if (e == acc_edge + 2) m_hi = m_z[2*W-1:W];
    if (e >= next_ok) begin
      if (s) begin
        m_z      = r;
        m_zz     = (r == '0);
        acc_edge = e;
        next_ok  = e + 4;
        sb.push_back('{done_edge: e + 2, z: r});
      end else begin
        if (hin) m_hi = b;
        if (lin) m_lo = b;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic doClear();
    @(posedge Clock);
    #2;
    Clear = 1'b1;
    start = 1'b0; HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
    #1;
    checkOutput("clr_HI", HI, '0);
    checkOutput("clr_LO", LO, '0);
    checkOutput("clr_Z", Z, '0);
    checkOutput("clr_z_zero", z_zero, '0);
    checkOutput("clr_busy", busy, '0);
    checkOutput("clr_done", done, '0);
    checkOutput("clr_bus_out", bus_out, '0);
    resetModel();
    @(posedge Clock);
    #2;
    Clear = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding writeback.
  always @(negedge Clock) begin
    if (!Clear) begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1'b1, 1'b0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          checkOutput("done_edge", 64'(edge_cnt), 64'(x.done_edge));
          checkOutput("done_Z", Z, x.z);
          checkOutput("done_HI", HI, x.z[2*W-1:W]);
          checkOutput("done_LO", LO, x.z[W-1:0]);
        end
      end else if (sb.size() != 0 && sb[0].done_edge <= edge_cnt) begin
        checkOutput("missing_done", 1'b0, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [2*W-1:0] r;
    Clear = 1'b1;
    start = 1'b0; result = '0; HIin = 1'b0; LOin = 1'b0;
    bus_in = '0; HIout = 1'b0; LOout = 1'b0;
    resetModel();
    repeat (2) @(posedge Clock);
    #2;
    Clear = 1'b0;

    idle(1);
    // Clear lands while WR_LO is in progress.
    applyStimulus(1'b1, 64'h0000_0001_0000_0002, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    doClear();
    idle(3);
    // Basic multiply, then negative product read back through the bus.
    applyStimulus(1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(4);
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    // Zero result; a second start during WR_HI must be dropped.
    applyStimulus(1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b1, 64'h5, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(4);
    // mthi, then start beating mtlo, then mthi while busy.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h7, 1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle(4);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        doClear();
      end else begin
        r = ($urandom_range(7) == 0) ? '0 : {$urandom, $urandom};
        applyStimulus($urandom_range(2) == 0, r, $urandom_range(3) == 0,
                      $urandom_range(3) == 0, $urandom, $urandom_range(1) == 1,
                      $urandom_range(1) == 1);
      end
    end
    idle(6);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
